// File: rtl/game_judge.sv
`default_nettype none
// ============================================================================
// Module   : game_judge
// Brief    : Scoring and termination stage behind the typing-game controller.
// Revision : 1.0 - initial release
// ============================================================================
module game_judge #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state_i,
  input  logic             mode_i,
  input  logic [6:0]       value_i,
  input  logic             key_valid_i,
  input  logic [7:0]       key_char_i,
  input  logic [7:0]       target_char_i,
  input  logic             target_last_i,
  output logic             char_adv_o,
  output logic             finish_o,
  output logic [6:0]       remain_o,
  output logic [6:0]       elapsed_sec_o,
  output logic [6:0]       words_done_o,
  output logic [CNT_W-1:0] correct_cnt_o,
  output logic [CNT_W-1:0] error_cnt_o
);

  localparam int                   C_PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } ctrl_state_e;

  ctrl_state_e            state_q;
  logic [C_PRESC_W-1:0]   presc_q,    presc_d;
  logic                   char_adv_q, char_adv_d;
  logic                   finish_q,   finish_d;
  logic [6:0]             remain_q,   remain_d;
  logic [6:0]             elapsed_q,  elapsed_d;
  logic [6:0]             words_q,    words_d;
  logic [CNT_W-1:0]       correct_q,  correct_d;
  logic [CNT_W-1:0]       error_q,    error_d;

  logic w_setup;
  logic w_entry;
  logic w_match;
  logic w_sec_tick;

  assign w_setup = (state_i == ST_SELECT) || (state_i == ST_COUNTDOWN);
  assign w_entry = (state_i == ST_INGAME) && (state_q != ST_INGAME);
  assign w_match = (key_char_i == target_char_i);

  always_comb begin
    presc_d    = presc_q;
    char_adv_d = 1'b0;
    finish_d   = finish_q;
    remain_d   = remain_q;
    elapsed_d  = elapsed_q;
    words_d    = words_q;
    correct_d  = correct_q;
    error_d    = error_q;
    w_sec_tick = 1'b0;

    if (w_setup) begin
      presc_d   = '0;
      finish_d  = 1'b0;
      remain_d  = '0;
      elapsed_d = '0;
      words_d   = '0;
      correct_d = '0;
      error_d   = '0;
    end else if (w_entry) begin
      // A zero target ends the session on the very first edge in either mode.
      presc_d   = '0;
      remain_d  = value_i;
      finish_d  = (value_i == 7'd0);
      elapsed_d = '0;
      words_d   = '0;
      correct_d = '0;
      error_d   = '0;
    end else if ((state_i == ST_INGAME) && !finish_q) begin
      if (presc_q == C_PRESC_MAX) begin
        presc_d    = '0;
        w_sec_tick = 1'b1;
      end else begin
        presc_d = presc_q + C_PRESC_W'(1);
      end

      if (w_sec_tick) begin
        elapsed_d = (&elapsed_q) ? elapsed_q : elapsed_q + 7'd1;
        if (!mode_i && (remain_q != 7'd0)) begin
          remain_d = remain_q - 7'd1;
          if (remain_q == 7'd1) finish_d = 1'b1;
        end
      end

      // Time decrements remain in mode 0, words in mode 1, so both never collide.
      if (key_valid_i) begin
        if (w_match) begin
          char_adv_d = 1'b1;
          correct_d  = (&correct_q) ? correct_q : correct_q + CNT_W'(1);
          if (target_last_i) begin
            words_d = (&words_q) ? words_q : words_q + 7'd1;
            if (mode_i && (remain_q != 7'd0)) begin
              remain_d = remain_q - 7'd1;
              if (remain_q == 7'd1) finish_d = 1'b1;
            end
          end
        end else begin
          error_d = (&error_q) ? error_q : error_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SELECT;
      presc_q    <= '0;
      char_adv_q <= 1'b0;
      finish_q   <= 1'b0;
      remain_q   <= '0;
      elapsed_q  <= '0;
      words_q    <= '0;
      correct_q  <= '0;
      error_q    <= '0;
    end else begin
      state_q    <= ctrl_state_e'(state_i);
      presc_q    <= presc_d;
      char_adv_q <= char_adv_d;
      finish_q   <= finish_d;
      remain_q   <= remain_d;
      elapsed_q  <= elapsed_d;
      words_q    <= words_d;
      correct_q  <= correct_d;
      error_q    <= error_d;
    end
  end

  // Outside a running session remain previews the selected target.
  assign remain_o      = (w_setup || w_entry) ? value_i : remain_q;
  assign char_adv_o    = char_adv_q;
  assign finish_o      = finish_q;
  assign elapsed_sec_o = elapsed_q;
  assign words_done_o  = words_q;
  assign correct_cnt_o = correct_q;
  assign error_cnt_o   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_game_judge.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_judge
// Brief    : Scoreboard bench for game_judge with a 10-cycle game second.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_judge;

  localparam int CLK_HZ = 10;
  localparam int CNT_W  = 10;

  logic             clk         = 1'b0;
  logic             rst         = 1'b0;
  logic [1:0]       state       = 2'd0;
  logic             mode        = 1'b0;
  logic [6:0]       value       = 7'd0;
  logic             key_valid   = 1'b0;
  logic [7:0]       key_char    = 8'd0;
  logic [7:0]       target_char = 8'd0;
  logic             target_last = 1'b0;
  logic             char_adv;
  logic             finish;
  logic [6:0]       remain;
  logic [6:0]       elapsed_sec;
  logic [6:0]       words_done;
  logic [CNT_W-1:0] correct_cnt;
  logic [CNT_W-1:0] error_cnt;

  typedef struct packed {
    logic             adv;
    logic             fin;
    logic [6:0]       rem;
    logic [6:0]       el;
    logic [6:0]       wd;
    logic [CNT_W-1:0] cor;
    logic [CNT_W-1:0] err;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       m;
  logic [1:0] m_prev_state = 2'd0;
  int         m_cyc        = 0;
  int         checks       = 0;
  int         failures     = 0;

  always #5 clk = ~clk;

  game_judge #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .state_i       (state),
    .mode_i        (mode),
    .value_i       (value),
    .key_valid_i   (key_valid),
    .key_char_i    (key_char),
    .target_char_i (target_char),
    .target_last_i (target_last),
    .char_adv_o    (char_adv),
    .finish_o      (finish),
    .remain_o      (remain),
    .elapsed_sec_o (elapsed_sec),
    .words_done_o  (words_done),
    .correct_cnt_o (correct_cnt),
    .error_cnt_o   (error_cnt)
  );

  function automatic obs_t sample();
    return {char_adv, finish, remain, elapsed_sec, words_done, correct_cnt, error_cnt};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("adv=%0b fin=%0b rem=%0d el=%0d wd=%0d cor=%0d err=%0d",
                     o.adv, o.fin, o.rem, o.el, o.wd, o.cor, o.err);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outputs expected after the next edge for the inputs now driven.
  task automatic predict();
    obs_t n;
    n     = m;
    n.adv = 1'b0;
    if (state == 2'd0 || state == 2'd1) begin
      n     = '0;
      n.rem = value;
      m_cyc = 0;
    end else if (state == 2'd2 && m_prev_state != 2'd2) begin
      n     = '0;
      n.rem = value;
      n.fin = (value == 7'd0);
      m_cyc = 0;
    end else if (state == 2'd2 && !m.fin) begin
      m_cyc = m_cyc + 1;
      if (m_cyc % CLK_HZ == 0) begin
        if (n.el != 7'h7f) n.el = n.el + 7'd1;
        if (!mode && n.rem != 7'd0) begin
          n.rem = n.rem - 7'd1;
          if (n.rem == 7'd0) n.fin = 1'b1;
        end
      end
      if (key_valid) begin
        if (key_char == target_char) begin
          n.adv = 1'b1;
          if (n.cor != '1) n.cor = n.cor + CNT_W'(1);
          if (target_last) begin
            if (n.wd != 7'h7f) n.wd = n.wd + 7'd1;
            if (mode && n.rem != 7'd0) begin
              n.rem = n.rem - 7'd1;
              if (n.rem == 7'd0) n.fin = 1'b1;
            end
          end
        end else if (n.err != '1) begin
          n.err = n.err + CNT_W'(1);
        end
      end
    end
    m_prev_state = state;
    m            = n;
  endtask

  // SELECT -> COUNTDOWN -> INGAME; the entry-edge expectation is left on the queue.
  task automatic enter_ingame(input logic md, input logic [6:0] val);
    mode        = md;
    value       = val;
    key_valid   = 1'b0;
    target_last = 1'b0;
    state = 2'd0; predict(); step();
    state = 2'd1; predict(); step();
    state = 2'd2; predict(); exp_q.push_back(m); step();
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    m   = '0;
    m_prev_state = 2'd0;
    m_cyc = 0;
    exp_q.push_back(m);
    step(); step();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset: got %s want %s", fmt(o), fmt(e)); end
    rst   = 1'b0;
    state = 2'd1;
    value = 7'd42;
    predict(); exp_q.push_back(m); step();
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL preview: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_timer();
    obs_t o, e;
    enter_ingame(1'b0, 7'd15);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL timer_entry: got %s want %s", fmt(o), fmt(e)); end
    for (int k = 1; k <= 166; k++) begin
      if (k > 160) state = (k == 166) ? 2'd0 : 2'd3;
      predict(); exp_q.push_back(m); step();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL timer[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_words();
    obs_t o, e;
    int idx = 0;
    int adv_seen = 0;
    enter_ingame(1'b1, 7'd25);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL words_entry: got %s want %s", fmt(o), fmt(e)); end
    for (int k = 0; k < 130; k++) begin
      target_char = 8'h61 + 8'(idx % 26);
      target_last = (idx % 5 == 4);
      key_char    = target_char;
      key_valid   = 1'b1;
      predict(); exp_q.push_back(m); step();
      key_valid = 1'b0;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL words_key[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
      if (char_adv) begin adv_seen++; idx++; end
      predict(); exp_q.push_back(m); step();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL words_idle[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
      if (char_adv) adv_seen++;
    end
    checks++;
    if (adv_seen != 125) begin
      failures++; $display("FAIL words_adv_pulses: got %0d want 125", adv_seen);
    end
  endtask

  task automatic test_mismatch();
    obs_t o, e;
    enter_ingame(1'b1, 7'd3);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL mis_entry: got %s want %s", fmt(o), fmt(e)); end
    target_char = "a";
    target_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      key_valid = (k % 2 == 0);
      key_char  = (k == 0) ? 8'h62 : 8'h61;
      predict(); exp_q.push_back(m); step();
      key_valid = 1'b0;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL mis[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_coincident();
    obs_t o, e;
    enter_ingame(1'b0, 7'd1);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL coin_entry: got %s want %s", fmt(o), fmt(e)); end
    target_char = "q";
    target_last = 1'b1;
    key_char    = "q";
    for (int k = 1; k <= 12; k++) begin
      key_valid = (k == 10);
      predict(); exp_q.push_back(m); step();
      key_valid = 1'b0;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL coin[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_zero_target();
    obs_t o, e;
    enter_ingame(1'b1, 7'd0);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL zero_entry: got %s want %s", fmt(o), fmt(e)); end
    target_char = "z";
    target_last = 1'b1;
    key_char    = "z";
    for (int k = 0; k < 6; k++) begin
      key_valid = (k == 0);
      predict(); exp_q.push_back(m); step();
      key_valid = 1'b0;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL zero[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_abort();
    obs_t o, e;
    enter_ingame(1'b1, 7'd20);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL abort_entry: got %s want %s", fmt(o), fmt(e)); end
    target_char = "k";
    target_last = 1'b0;
    key_char    = "k";
    // Seven keys on even steps; the jump to SELECT follows the seventh key directly.
    for (int k = 0; k < 14; k++) begin
      key_valid = (k % 2 == 0);
      if (k == 13) state = 2'd0;
      predict(); exp_q.push_back(m); step();
      key_valid = 1'b0;
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL abort[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
    end
    enter_ingame(1'b1, 7'd20);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL abort_reenter: got %s want %s", fmt(o), fmt(e)); end
    key_valid = 1'b1;
    predict(); exp_q.push_back(m); step();
    key_valid = 1'b0;
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL abort_newkey: got %s want %s", fmt(o), fmt(e)); end
    // Asynchronous reset between edges while char_adv is still high.
    #2;
    rst   = 1'b1;
    state = 2'd0;
    m     = '0;
    m.rem = value;
    m_prev_state = 2'd0;
    m_cyc = 0;
    exp_q.push_back(m);
    #1;
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL async_rst: got %s want %s", fmt(o), fmt(e)); end
    step();
    rst = 1'b0;
    enter_ingame(1'b1, 7'd20);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rst_reenter: got %s want %s", fmt(o), fmt(e)); end
    key_valid = 1'b1;
    predict(); exp_q.push_back(m); step();
    key_valid = 1'b0;
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rst_newkey: got %s want %s", fmt(o), fmt(e)); end
  endtask

  // Held wrong key every cycle: error_cnt and elapsed_sec both reach saturation.
  task automatic test_back_to_back();
    obs_t o, e;
    enter_ingame(1'b1, 7'd3);
    e = exp_q.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL b2b_entry: got %s want %s", fmt(o), fmt(e)); end
    target_char = "a";
    target_last = 1'b0;
    key_char    = "z";
    for (int k = 0; k < 1330; k++) begin
      key_valid = (k < 1030);
      predict(); exp_q.push_back(m); step();
      e = exp_q.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL b2b[%0d]: got %s want %s", k, fmt(o), fmt(e)); end
    end
    key_valid = 1'b0;
    checks++;
    if (error_cnt !== {CNT_W{1'b1}} || elapsed_sec !== 7'h7f) begin
      failures++;
      $display("FAIL saturation: got err=%0d el=%0d want err=%0d el=127", error_cnt, elapsed_sec, {CNT_W{1'b1}});
    end
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timer();
    test_words();
    test_mismatch();
    test_coincident();
    test_zero_target();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
